// File: rtl/uart_rx_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_counter
//
// Oversampling timebase for the UART receiver. Counts oversample clock edges
// within each bit and bits within each frame, and decodes the strobes used by
// the data sampler and the RX FSM.
//
// Prescale and frame length are captured on the first enabled edge of a frame.
// Later changes on those inputs are ignored until enable is dropped and
// reasserted. An invalid captured configuration parks the block in an error
// state with cfg_err high and the counters at zero.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   enable      high while a frame is being received; low clears the block
//   prescale    oversample edges per bit (even, >= 4)
//   frame_len   bits per frame, start..stop inclusive (>= 2)
//   edge_cnt    edge index within the current bit, 0..P-1
//   bit_cnt     bit index within the current frame, 0..L-1
//   sample_stb  high on the three majority-vote sample edges
//   sample_mid  high on the centre sample edge only
//   bit_done    pulse on the last edge of each bit
//   frame_done  pulse on the last edge of the last bit of a frame
//   cfg_err     captured configuration is invalid
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_len,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_stb,
  output logic                  sample_mid,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [PRESCALE_W-1:0] P_ZERO = '0;
  localparam logic [PRESCALE_W-1:0] P_ONE  = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN  = PRESCALE_W'(4);
  localparam logic [BIT_CNT_W-1:0]  L_ZERO = '0;
  localparam logic [BIT_CNT_W-1:0]  L_ONE  = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]  L_MIN  = BIT_CNT_W'(2);

  // A prescale below 4 leaves no room for three distinct sample edges, and an
  // odd prescale has no exact centre edge.
  function automatic logic cfg_invalid(input logic [PRESCALE_W-1:0] p,
                                       input logic [BIT_CNT_W-1:0]  l);
    return (p < P_MIN) || p[0] || (l < L_MIN);
  endfunction

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_q, edge_d;
  logic [BIT_CNT_W-1:0]    bit_q, bit_d;
  logic [PRESCALE_W-1:0]   p_q, p_d;
  logic [BIT_CNT_W-1:0]    l_q, l_d;

  logic                    active_q;
  logic                    err_q;
  logic                    last_edge;
  logic                    last_bit;
  logic [PRESCALE_W-1:0]   half_p;
  logic                    qual;

  assign active_q  = (state_q != ST_IDLE);
  assign err_q     = (state_q == ST_ERROR);
  assign last_edge = (edge_q == (p_q - P_ONE));
  assign last_bit  = (bit_q == (l_q - L_ONE));
  assign half_p    = p_q >> 1;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    l_d     = l_q;

    if (!enable) begin
      state_d = ST_IDLE;
      edge_d  = P_ZERO;
      bit_d   = L_ZERO;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          p_d = prescale;
          l_d = frame_len;
          if (cfg_invalid(prescale, frame_len)) begin
            state_d = ST_ERROR;
            edge_d  = P_ZERO;
            bit_d   = L_ZERO;
          end else begin
            // The capturing edge is itself edge 0 of bit 0.
            state_d = ST_COUNT;
            edge_d  = P_ONE;
            bit_d   = L_ZERO;
          end
        end
        ST_COUNT: begin
          if (last_edge) begin
            edge_d = P_ZERO;
            // Wrap straight into the next frame so back-to-back frames run
            // without a dead cycle.
            bit_d  = last_bit ? L_ZERO : (bit_q + L_ONE);
          end else begin
            edge_d = edge_q + P_ONE;
          end
        end
        ST_ERROR: begin
          edge_d = P_ZERO;
          bit_d  = L_ZERO;
        end
        default: begin
          state_d = ST_IDLE;
          edge_d  = P_ZERO;
          bit_d   = L_ZERO;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      edge_q  <= P_ZERO;
      bit_q   <= L_ZERO;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
    end
  end

  // Captured configuration is only consulted while active, so it needs no reset.
  always_ff @(posedge clk) begin
    p_q <= p_d;
    l_q <= l_d;
  end

  // ---------------------------------------------------------------------------
  // Strobe decode
  // ---------------------------------------------------------------------------
  assign qual = active_q & ~err_q & enable;

  assign edge_cnt   = edge_q;
  assign bit_cnt    = bit_q;
  assign cfg_err    = err_q;
  assign sample_stb = qual & ((edge_q == (half_p - P_ONE)) ||
                              (edge_q == half_p) ||
                              (edge_q == (half_p + P_ONE)));
  assign sample_mid = qual & (edge_q == half_p);
  assign bit_done   = qual & last_edge;
  assign frame_done = qual & last_edge & last_bit;

endmodule

// File: doc/uart_rx_edge_bit_counter.md
# uart_rx_edge_bit_counter

Parametrised oversampling timebase for the UART receiver. It counts oversample clock edges within each bit and bits within each frame, and produces the strobes that the data sampler and RX FSM consume: mid-bit sample points, bit-done and frame-done. Prescale and frame length are runtime-configurable. Both are captured at frame start, so mid-frame changes cannot corrupt a frame in progress.

## Interface
Parameters:
- PRESCALE_W, default 6: width of `prescale`; maximum usable prescale is 2^PRESCALE_W − 2.
- BIT_CNT_W, default 4: width of `frame_len` and `bit_cnt`; maximum frame is 2^BIT_CNT_W − 1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  high while the RX FSM is receiving a frame; low clears the block.
- prescale  in  PRESCALE_W  oversample edges per bit; must be even and ≥ 4.
- frame_len  in  BIT_CNT_W  total bits per frame (start + data + parity + stop); must be ≥ 2.
- edge_cnt  out  PRESCALE_W  edge index within the current bit, 0..P−1.
- bit_cnt  out  BIT_CNT_W  bit index within the current frame, 0..L−1.
- sample_stb  out  1  high on the three majority-vote sample edges.
- sample_mid  out  1  high on the centre sample edge only.
- bit_done  out  1  one-cycle pulse on the last edge of each bit.
- frame_done  out  1  one-cycle pulse on the last edge of the last bit.
- cfg_err  out  1  captured configuration is invalid.

## Operation
- Internal state:
  - `active_q` flag.
  - Captured config `P_q` and `L_q`.
  - `edge_cnt` and `bit_cnt` registers.
  - `cfg_err` register.
- IDLE (`active_q` = 0), on a clock edge with `enable` = 1:
  - Capture `P_q` ← `prescale` and `L_q` ← `frame_len`.
  - Set `active_q`.
  - If `prescale` < 4, or `prescale` is odd, or `frame_len` < 2: set `cfg_err`, keep the counters at 0, and enter ERROR.
  - Otherwise enter COUNT. This same edge counts as edge 0 → `edge_cnt` = 1.
- COUNT, on each edge with `enable` = 1:
  - If `edge_cnt` == `P_q` − 1: `edge_cnt` ← 0.
    - If `bit_cnt` == `L_q` − 1: `bit_cnt` ← 0, remain in COUNT. Back-to-back frames need no re-enable.
    - Otherwise: `bit_cnt` ← `bit_cnt` + 1.
  - Otherwise: `edge_cnt` ← `edge_cnt` + 1.
- ERROR: counters held at 0, all strobes low, `cfg_err` held high.
- Any state, on an edge with `enable` = 0: `active_q`, `edge_cnt`, `bit_cnt` and `cfg_err` all ← 0, and the state returns to IDLE. Configuration is re-captured on the next enable.
- Changes to `prescale` or `frame_len` while `active_q` = 1 are ignored.
- Strobes are combinational decodes of the registered counters, qualified by `active_q` & ~`cfg_err` & `enable`:
  - `sample_stb` = (`edge_cnt` ∈ {P_q/2 − 1, P_q/2, P_q/2 + 1}).
  - `sample_mid` = (`edge_cnt` == P_q/2).
  - `bit_done` = (`edge_cnt` == P_q − 1).
  - `frame_done` = `bit_done` & (`bit_cnt` == L_q − 1).
- Arithmetic: all compares are unsigned at the full port width. P_q/2 is a right shift. No counter ever exceeds its captured limit minus 1.

## Timing
- Reset (`rst_n` = 0 at a rising edge) has priority over `enable`. After reset all outputs are 0 and the state is IDLE.
- Reset asserted mid-frame: everything is 0 on the next edge, with no frame_done pulse.
- Strobes have zero latency relative to the counter values. They are valid in the cycle in which `edge_cnt` holds the decoded value.
- One bit lasts exactly P_q cycles of `enable` high. One frame lasts exactly P_q·L_q cycles.
- `frame_done` coincides with the final `bit_done`. On the following edge both counters read 0.
- `enable` falling in the same cycle as `frame_done`: the pulse is suppressed, because it is qualified by `enable`, and the counters clear.
- With P_q = 4, the sample edges are 1, 2 and 3, so the last sample coincides with `bit_done`. This is legal.

## Test plan
- Reset, then `prescale` = 8, `frame_len` = 10, enable held for 80 cycles:
  - `bit_done` pulses every 8 cycles.
  - `sample_mid` is high when `edge_cnt` = 4.
  - `sample_stb` is high when `edge_cnt` = 3, 4 and 5.
  - `frame_done` is high exactly once, in cycle 80. `bit_cnt` and `edge_cnt` then read 0.
- `prescale` = 16, `frame_len` = 11, `prescale` changed to 8 during bit 3: the frame still lasts 176 cycles and `sample_mid` stays at `edge_cnt` = 8.
- `prescale` = 8, enable dropped after 37 cycles: next edge shows `edge_cnt` = 0, `bit_cnt` = 0 and no strobes. Re-enabling with `prescale` = 16 then runs at 16.
- `prescale` = 5, or `prescale` = 2, or `frame_len` = 1:
  - `cfg_err` = 1 after the first enabled edge and the counters stay 0.
  - Dropping enable clears `cfg_err` on the next edge.
- `rst_n` = 0 asserted at bit 6, edge 3, with enable held high: all outputs 0 on the next edge. After release, counting restarts at `edge_cnt` = 1 with freshly captured config.
- Enable held for 3 frames, `prescale` = 8, `frame_len` = 10: `frame_done` fires at cycles 80, 160 and 240, with no dead cycle between frames.
